// File: rtl/fifo_arb_pkg.sv
// Shared constants and types for the FIFO drain arbiter.
package fifo_arb_pkg;

    localparam int NCH = 4;   // number of source FIFOs
    localparam int DW  = 6;   // word width per channel
    localparam int GW  = 2;   // grant / channel index width
    localparam int CW  = 4;   // burst counter width (BURST up to 15)

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // Channel index k steps after g, wrapping modulo NCH.
    function automatic logic [GW-1:0] grant_add(input logic [GW-1:0] g, input logic [GW-1:0] k);
        return g + k;
    endfunction

endpackage

// File: rtl/fifo_drain_arb_rr_pick4.sv
// Next-grant picker: rotating search starting after the current grant,
// with optional fixed priority for channel 0.
module rr_pick4
    import fifo_arb_pkg::*;
(
    input  logic [NCH-1:0] empty,
    input  logic [GW-1:0]  g,
    input  logic           prio,
    output logic [GW-1:0]  g_next,
    output logic           any
);

    // Walk the search order backwards so the earliest non-empty candidate wins;
    // k = NCH wraps back to the current grant, which is considered last.
    always_comb begin
        g_next = g;
        any    = ~&empty;
        for (int k = NCH; k >= 1; k--) begin
            if (!empty[grant_add(g, GW'(k))]) begin
                g_next = grant_add(g, GW'(k));
            end
        end
        // With channel 0 empty the rotation above already skips it, so
        // channels 1-3 keep round-robin order among themselves.
        if (prio && !empty[0]) begin
            g_next = '0;
        end
    end

endmodule

// File: rtl/fifo_drain_arb.sv
// Drains four channel FIFOs into one registered output stream, granting one
// channel at a time for up to BURST words. Channel switches take one
// arbitration cycle. Define FIFO_ARB_PRIO_EN to give channel 0 absolute
// priority at every arbitration; otherwise pure 4-way round-robin.
module fifo_drain_arb
    import fifo_arb_pkg::*;
#(
    parameter int BURST = 4
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    empty,
    input  logic [NCH*DW-1:0] pdi,
    output logic [NCH-1:0]    oe,
    input  logic              rdy,
    output logic [DW-1:0]     pdo,
    output logic [GW-1:0]     ch,
    output logic              ov
);

`ifdef FIFO_ARB_PRIO_EN
    localparam logic PRIO = 1'b1;
`else
    localparam logic PRIO = 1'b0;
`endif

    localparam logic [CW-1:0] LAST = CW'(BURST - 1);

    state_t          state;
    state_t          state_nxt;
    logic [GW-1:0]   g;
    logic [GW-1:0]   g_nxt;
    logic [GW-1:0]   g_pick;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            any;
    logic            fire;
    logic [DW-1:0]   pdi_sel;

    rr_pick4 u_pick (
        .empty  (empty),
        .g      (g),
        .prio   (PRIO),
        .g_next (g_pick),
        .any    (any)
    );

    // Read strobe for the granted channel; a held word that is not being
    // accepted blocks the next read so nothing is lost during a stall.
    always_comb begin
        fire  = (state == ST_XFER) && !empty[g] && (!ov || rdy);
        oe    = '0;
        oe[g] = fire;
    end

    // Select the granted channel's read data.
    always_comb begin
        pdi_sel = '0;
        for (int n = 0; n < NCH; n++) begin
            if (g == GW'(n)) begin
                pdi_sel = pdi[n*DW +: DW];
            end
        end
    end

    // Next-state, next-grant and burst counter.
    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        cnt_nxt   = cnt;
        case (state)
            ST_ARB: begin
                if (any) begin
                    g_nxt     = g_pick;
                    cnt_nxt   = '0;
                    state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (fire) begin
                    cnt_nxt = cnt + CW'(1);
                end
                // An emptied channel gives up the rest of its burst.
                if ((fire && (cnt == LAST)) || empty[g]) begin
                    state_nxt = ST_ARB;
                end
            end
            default: begin
                state_nxt = ST_ARB;
            end
        endcase
    end

    // FSM, grant and counter registers; grant resets to 3 so the first
    // search begins at channel 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_ARB;
            g     <= '1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Output word register: load on strobe, drop valid once accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pdo <= '0;
            ch  <= '0;
            ov  <= 1'b0;
        end else if (fire) begin
            pdo <= pdi_sel;
            ch  <= g;
            ov  <= 1'b1;
        end else if (rdy) begin
            ov  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_drain_arb.sv
// Bench for fifo_drain_arb: queue-backed channel FIFOs, a cycle-level
// behavioural model, a table of drain scenarios and a few hand sequences.
module tb_fifo_drain_arb;

    localparam int BURST = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  empty;
    logic [23:0] pdi;
    logic [3:0]  oe;
    logic        rdy;
    logic [5:0]  pdo;
    logic [1:0]  ch;
    logic        ov;

    fifo_drain_arb #(.BURST(BURST)) dut (
        .clk   (clk),
        .rst   (rst),
        .empty (empty),
        .pdi   (pdi),
        .oe    (oe),
        .rdy   (rdy),
        .pdo   (pdo),
        .ch    (ch),
        .ov    (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    string phase = "init";

    logic [5:0] q [4][$];
    int         seq [4];
    int         acc_ch [$];
    logic [5:0] acc_w [$];

    // model state
    bit         m_xfer;
    int         m_g;
    int         m_cnt;
    logic [5:0] m_pdo;
    int         m_ch;
    bit         m_ov;

    typedef struct {
        string       name;
        logic [15:0] fill;     // words per channel, channel n in nibble n
        int          rdy_pct;
        string       exp_rr;   // accepted channel order, round-robin build
        string       exp_prio; // accepted channel order, channel-0 priority build
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0h expected %0h", phase, nm, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] e, input int g);
`ifdef FIFO_ARB_PRIO_EN
        if (!e[0]) return 0;
`endif
        for (int k = 1; k <= 4; k++) begin
            if (!e[(g + k) % 4]) return (g + k) % 4;
        end
        return g;
    endfunction

    task automatic push_word(input int n);
        q[n].push_back({2'(n), 4'(seq[n])});
        seq[n]++;
    endtask

    task automatic drive_fifo();
        for (int n = 0; n < 4; n++) begin
            empty[n]     = (q[n].size() == 0);
            pdi[6*n +: 6] = (q[n].size() != 0) ? q[n][0] : 6'h0;
        end
    endtask

    task automatic model_reset();
        m_xfer = 1'b0;
        m_g    = 3;
        m_cnt  = 0;
        m_pdo  = '0;
        m_ch   = 0;
        m_ov   = 1'b0;
    endtask

    function automatic bit idle();
        return (q[0].size() == 0) && (q[1].size() == 0) && (q[2].size() == 0) &&
               (q[3].size() == 0) && !m_ov && !m_xfer;
    endfunction

    // Entered just after a falling edge; drives inputs, compares against the
    // model, advances the model to the next rising edge, returns at the next
    // falling edge.
    task automatic cycle(input bit r);
        logic [3:0] e;
        logic [3:0] m_oe;
        rdy = r;
        drive_fifo();
        e = empty;
        #1;
        m_oe = '0;
        if (m_xfer && !e[m_g] && (!m_ov || r)) m_oe[m_g] = 1'b1;
        chk("oe",  32'(oe),  32'(m_oe));
        chk("ov",  32'(ov),  32'(m_ov));
        chk("pdo", 32'(pdo), 32'(m_pdo));
        chk("ch",  32'(ch),  32'(m_ch));
        if (ov && rdy) begin
            acc_ch.push_back(int'(ch));
            acc_w.push_back(pdo);
        end
        if (!m_xfer) begin
            if (m_ov && r) m_ov = 1'b0;
            if (e != 4'hF) begin
                m_g    = pick(e, m_g);
                m_cnt  = 0;
                m_xfer = 1'b1;
            end
        end else if (m_oe != 4'h0) begin
            m_pdo = q[m_g].pop_front();
            m_ch  = m_g;
            m_ov  = 1'b1;
            m_cnt++;
            if (m_cnt == BURST) m_xfer = 1'b0;
        end else begin
            if (m_ov && r) m_ov = 1'b0;
            if (e[m_g]) m_xfer = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input bit clear);
        rst = 1'b0;
        if (clear) begin
            for (int n = 0; n < 4; n++) begin
                q[n].delete();
                seq[n] = 0;
            end
        end
        drive_fifo();
        #1;
        chk("rst_oe",  32'(oe),  32'h0);
        chk("rst_ov",  32'(ov),  32'h0);
        chk("rst_pdo", 32'(pdo), 32'h0);
        chk("rst_ch",  32'(ch),  32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_to_idle(input int rdy_pct, input int min_cyc);
        int cyc;
        cyc = 0;
        while ((cyc < min_cyc || !idle()) && cyc < 400) begin
            cycle($urandom_range(99) < rdy_pct);
            cyc++;
        end
        chk("drain_timeout", 32'(cyc >= 400), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string exp;
        int    n0;

        vecs[0] = '{"all_empty",  16'h0000, 100, "", ""};
        vecs[1] = '{"ch0_only10", 16'h000A, 100, "0000000000", "0000000000"};
        vecs[2] = '{"all_two",    16'h2222, 100, "00112233", "00112233"};
        vecs[3] = '{"all_five",   16'h5555, 100, "00001111222233330123", "00000111122223333123"};
        vecs[4] = '{"ch1_ch2",    16'h0630, 100, "111222222", "111222222"};
        vecs[5] = '{"all_five_stall", 16'h5555, 55, "00001111222233330123", "00000111122223333123"};

        rst   = 1'b0;
        rdy   = 1'b0;
        empty = 4'hF;
        pdi   = '0;
        @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            phase = vecs[t].name;
            do_reset(1'b1);
            for (int n = 0; n < 4; n++) begin
                for (int k = 0; k < int'(vecs[t].fill[4*n +: 4]); k++) push_word(n);
            end
            acc_ch.delete();
            acc_w.delete();
            run_to_idle(vecs[t].rdy_pct, 10);
`ifdef FIFO_ARB_PRIO_EN
            exp = vecs[t].exp_prio;
`else
            exp = vecs[t].exp_rr;
`endif
            chk("n_words", 32'(acc_ch.size()), 32'(exp.len()));
            for (int i = 0; i < exp.len() && i < acc_ch.size(); i++) begin
                chk($sformatf("word%0d_ch", i), 32'(acc_ch[i]), 32'(int'(exp[i]) - 48));
            end
        end

        // Three-cycle downstream stall in the middle of a channel-0 burst.
        phase = "stall";
        do_reset(1'b1);
        for (int k = 0; k < 6; k++) push_word(0);
        acc_ch.delete();
        acc_w.delete();
        repeat (3) cycle(1'b1);
        chk("stall_ov_before", 32'(ov), 32'h1);
        repeat (3) cycle(1'b0);
        run_to_idle(100, 0);
        chk("stall_n_words", 32'(acc_w.size()), 32'd6);
        for (int i = 0; i < 6 && i < acc_w.size(); i++) begin
            chk($sformatf("stall_word%0d", i), 32'(acc_w[i]), 32'(i));
        end

        // Reset while a word is held, then first grant to channel 0.
        phase = "rst_mid";
        do_reset(1'b1);
        for (int k = 0; k < 5; k++) push_word(1);
        repeat (3) cycle(1'b1);
        for (int k = 0; k < 3; k++) push_word(0);
        cycle(1'b0);
        chk("pre_rst_ov", 32'(ov), 32'h1);
        #2;
        do_reset(1'b0);
        acc_ch.delete();
        acc_w.delete();
        run_to_idle(100, 0);
        n0 = (acc_ch.size() > 0) ? acc_ch[0] : -1;
        chk("first_ch_after_rst", 32'(n0), 32'h0);
        chk("words_after_rst", 32'(acc_ch.size()), 32'd6);

        // Randomised traffic against the model.
        phase = "random";
        do_reset(1'b1);
        for (int c = 0; c < 800; c++) begin
            for (int n = 0; n < 4; n++) begin
                if ($urandom_range(99) < 9 && q[n].size() < 10) push_word(n);
            end
            cycle($urandom_range(99) < 65);
        end
        run_to_idle(100, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
